spi_cmd_dispatcher: RTL and testbench

//  Receives 24-bit SPI frames {x[7:0],y[7:0],data[7:0]} and schedules them onto the display write port.

---
 rtl/spi_cmd_dispatcher.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_cmd_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_dispatcher.sv
`timescale 1ns/1ps
// spi_cmd_dispatcher
// Receives 24-bit SPI frames {x, y, data}, oversampled in the CLOCK_50 domain,
// queues whole frames in a small FIFO and dispatches them onto the framebuffer
// write port: one pixel write per command, or a full-grid sweep for a clear.
// Ports:
//   CLOCK_50, RESET_N           system clock, async active-low reset
//   SPI_CLK, SPI_CS, SPI_DATA   asynchronous SPI link from the MCU (mode: sample on SPI_CLK fall)
//   wr_valid/wr_ready           framebuffer write handshake
//   wr_x, wr_y, wr_data         write payload, held stable while wr_valid & !wr_ready
//   busy                        dispatcher active or commands queued
//   frame_err, overflow         1-cycle pulses: bad bit count / good frame dropped on full FIFO
//   range_err                   1-cycle pulse: out-of-grid pixel command discarded
//   last_cmd                    last command popped from the FIFO (debug display)
module spi_cmd_dispatcher #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GRID_W     = 32,
    parameter int unsigned GRID_H     = 16,
    parameter logic [7:0]  CLEAR_X    = 8'hFF
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        SPI_CLK,
    input  logic        SPI_CS,
    input  logic        SPI_DATA,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [7:0]  wr_x,
    output logic [7:0]  wr_y,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_err,
    output logic        overflow,
    output logic        range_err,
    output logic [23:0] last_cmd
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = 24;

    localparam logic [4:0] FRAME_BITS = 5'd24;
    localparam logic [4:0] CNT_MAX    = 5'd31;
    localparam logic [7:0] GRID_W8    = 8'(GRID_W);
    localparam logic [7:0] GRID_H8    = 8'(GRID_H);
    localparam logic [7:0] X_LAST     = 8'(GRID_W - 1);
    localparam logic [7:0] Y_LAST     = 8'(GRID_H - 1);
    localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    // ---------------- input synchronizers + edge history ----------------
    logic [1:0] clk_sync, cs_sync, dat_sync;
    logic       clk_hist, cs_hist;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync <= 2'b11;
            cs_sync  <= 2'b11;
            dat_sync <= 2'b00;
            clk_hist <= 1'b1;
            cs_hist  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], SPI_CLK};
            cs_sync  <= {cs_sync[0], SPI_CS};
            dat_sync <= {dat_sync[0], SPI_DATA};
            clk_hist <= clk_sync[1];
            cs_hist  <= cs_sync[1];
        end
    end

    logic cs_fall_c, cs_rise_c, clk_fall_c;
    assign cs_fall_c  = cs_hist & ~cs_sync[1];
    assign cs_rise_c  = ~cs_hist & cs_sync[1];
    // SPI_CLK edges only count while the synchronized chip select is low
    assign clk_fall_c = clk_hist & ~clk_sync[1] & ~cs_sync[1];

    // ---------------- frame receiver ----------------
    logic [FW-1:0] shift_reg;
    logic [4:0]    bit_cnt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (cs_fall_c) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clk_fall_c) begin
            shift_reg <= {shift_reg[FW-2:0], dat_sync[1]};
            if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // ---------------- command FIFO ----------------
    logic [FW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt, fifo_cnt_n;
    logic          frame_ok_c, fifo_full_c, push_c, pop_c;
    logic [1:0]    state, state_n;

    assign frame_ok_c  = cs_rise_c && (bit_cnt == FRAME_BITS);
    assign fifo_full_c = (fifo_cnt == FIFO_FULL_CNT);
    // a full FIFO drops the frame even if a pop happens in the same cycle
    assign push_c      = frame_ok_c && !fifo_full_c;
    assign pop_c       = (state == S_IDLE) && (fifo_cnt != CW'(0));

    always_comb begin
        fifo_cnt_n = fifo_cnt;
        if (push_c && !pop_c) begin
            fifo_cnt_n = fifo_cnt + CW'(1);
        end else if (!push_c && pop_c) begin
            fifo_cnt_n = fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt  <= fifo_cnt_n;
            frame_err <= cs_rise_c && (bit_cnt != FRAME_BITS);
            overflow  <= frame_ok_c && fifo_full_c;
        end
    end

    // ---------------- dispatcher FSM ----------------
    logic [FW-1:0] cmd, cmd_n, last_cmd_n;
    logic          wr_valid_n, range_err_n, busy_n;
    logic [7:0]    wr_x_n, wr_y_n, wr_data_n;
    logic [7:0]    cmd_x, cmd_y, cmd_d;

    assign cmd_x = cmd[23:16];
    assign cmd_y = cmd[15:8];
    assign cmd_d = cmd[7:0];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            cmd       <= '0;
            last_cmd  <= '0;
            wr_valid  <= 1'b0;
            wr_x      <= '0;
            wr_y      <= '0;
            wr_data   <= '0;
            range_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cmd       <= cmd_n;
            last_cmd  <= last_cmd_n;
            wr_valid  <= wr_valid_n;
            wr_x      <= wr_x_n;
            wr_y      <= wr_y_n;
            wr_data   <= wr_data_n;
            range_err <= range_err_n;
            busy      <= busy_n;
        end
    end

    // next state and next registered outputs
    always_comb begin
        state_n     = state;
        cmd_n       = cmd;
        last_cmd_n  = last_cmd;
        wr_valid_n  = wr_valid;
        wr_x_n      = wr_x;
        wr_y_n      = wr_y;
        wr_data_n   = wr_data;
        range_err_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (pop_c) begin
                    cmd_n      = fifo_mem[rd_ptr];
                    last_cmd_n = fifo_mem[rd_ptr];
                    state_n    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cmd_x == CLEAR_X) begin
                    state_n    = S_CLEAR;
                    wr_valid_n = 1'b1;
                    wr_x_n     = '0;
                    wr_y_n     = '0;
                    wr_data_n  = cmd_d;
                end else if ((cmd_x < GRID_W8) && (cmd_y < GRID_H8)) begin
                    state_n    = S_WRITE;
                    wr_valid_n = 1'b1;
                    wr_x_n     = cmd_x;
                    wr_y_n     = cmd_y;
                    wr_data_n  = cmd_d;
                end else begin
                    state_n     = S_IDLE;
                    range_err_n = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    state_n    = S_IDLE;
                    wr_valid_n = 1'b0;
                end
            end
            S_CLEAR: begin
                // raster sweep: x fastest, done after the last cell is accepted
                if (wr_ready) begin
                    if (wr_x == X_LAST) begin
                        wr_x_n = '0;
                        if (wr_y == Y_LAST) begin
                            state_n    = S_IDLE;
                            wr_valid_n = 1'b0;
                        end else begin
                            wr_y_n = wr_y + 8'd1;
                        end
                    end else begin
                        wr_x_n = wr_x + 8'd1;
                    end
                end
            end
            default: begin
                state_n    = S_IDLE;
                wr_valid_n = 1'b0;
            end
        endcase

        busy_n = (state_n != S_IDLE) || (fifo_cnt_n != CW'(0));
    end

endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for spi_cmd_dispatcher (small 4x2 grid).
module tb_spi_cmd_dispatcher;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk, spi_cs, spi_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x, wr_y, wr_data;
    logic        busy, frame_err, overflow, range_err;
    logic [23:0] last_cmd;

    spi_cmd_dispatcher #(
        .FIFO_DEPTH(DEPTH),
        .GRID_W    (W),
        .GRID_H    (H),
        .CLEAR_X   (8'hFF)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SPI_CLK  (spi_clk),
        .SPI_CS   (spi_cs),
        .SPI_DATA (spi_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .busy     (busy),
        .frame_err(frame_err),
        .overflow (overflow),
        .range_err(range_err),
        .last_cmd (last_cmd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q[$];
    int fe_exp = 0, ov_exp = 0, rg_exp = 0;
    int fe_cnt = 0, ov_cnt = 0, rg_cnt = 0;
    int acc_cnt = 0;
    int rdy_mode = 1;   // 0: held low, 1: held high, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference model: what a complete 24-bit frame should produce
    task automatic model_cmd(input logic [23:0] c, input bit drop);
        if (drop) begin
            ov_exp++;
        end else if (c[23:16] == 8'hFF) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++)
                    exp_q.push_back({8'(xx), 8'(yy), c[7:0]});
        end else if (int'(c[23:16]) < W && int'(c[15:8]) < H) begin
            exp_q.push_back(c);
        end else begin
            rg_exp++;
        end
    endtask

    // MSB-first frame, 8-cycle SPI_CLK period, ends right after CS rises
    task automatic spi_bits(input logic [31:0] w, input int n);
        spi_cs = 1'b0;
        cyc(4);
        for (int i = 0; i < n; i++) begin
            spi_data = w[n-1-i];
            cyc(4);
            spi_clk = 1'b0;
            cyc(4);
            spi_clk = 1'b1;
        end
        cyc(4);
        spi_cs = 1'b1;
    endtask

    task automatic send_cmd(input logic [23:0] c, input bit drop);
        model_cmd(c, drop);
        spi_bits({8'h00, c}, 24);
        cyc(8);
    endtask

    task automatic send_bad(input int n);
        fe_exp++;
        spi_bits($urandom, n);
        cyc(8);
    endtask

    task automatic check_pulses(input string name);
        check({name, "_frame_err_cnt"}, 32'(fe_cnt), 32'(fe_exp));
        check({name, "_overflow_cnt"},  32'(ov_cnt), 32'(ov_exp));
        check({name, "_range_err_cnt"}, 32'(rg_cnt), 32'(rg_exp));
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        int n = 0;
        repeat (8) @(negedge clk);
        while (!done && n < 3000) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !wr_valid) done = 1'b1;
            n++;
        end
        check({name, "_drained"}, 32'(done), 32'(1));
        check({name, "_busy"}, 32'(busy), 32'(0));
        check_pulses(name);
        cyc(1);
    endtask

    // wr_ready driver
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       wr_ready = 1'b0;
                1:       wr_ready = 1'b1;
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: pulse counting, payload stability, scoreboard compare
    bit          stab_pend = 1'b0;
    logic [23:0] stab_val;
    always @(negedge clk) begin
        if (!rst_n) begin
            stab_pend = 1'b0;
        end else begin
            if (frame_err) fe_cnt++;
            if (overflow)  ov_cnt++;
            if (range_err) rg_cnt++;
            if (stab_pend) begin
                check("valid_held", 32'(wr_valid), 32'(1));
                if (wr_valid) check("payload_stable", 32'({wr_x, wr_y, wr_data}), 32'(stab_val));
            end
            stab_pend = 1'b0;
            if (wr_valid && !wr_ready) begin
                stab_pend = 1'b1;
                stab_val  = {wr_x, wr_y, wr_data};
            end
            if (wr_valid && wr_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write", {wr_x, wr_y, wr_data});
                end else begin
                    check("write", 32'({wr_x, wr_y, wr_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] c;
        int base;
        bit reached;
        int r;
        int nb;

        rst_n    = 1'b0;
        spi_clk  = 1'b1;
        spi_cs   = 1'b1;
        spi_data = 1'b0;
        cyc(3);
        check("rst_wr_valid", 32'(wr_valid), 32'(0));
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_last_cmd", 32'(last_cmd), 32'(0));
        check("rst_wr_xyd",   32'({wr_x, wr_y, wr_data}), 32'(0));
        rst_n = 1'b1;
        cyc(4);

        // single write with latency check (sync 2 cycles, then push/pop/load/write)
        rdy_mode = 1;
        cyc(2);
        model_cmd(24'h0301A7, 1'b0);
        spi_bits(32'h000301A7, 24);
        repeat (5) @(negedge clk);
        check("lat_before", 32'(wr_valid), 32'(0));
        @(negedge clk);
        check("lat_at",     32'(wr_valid), 32'(1));
        cyc(1);
        wait_idle("single");
        check("last_cmd", 32'(last_cmd), 32'(24'h0301A7));

        // bad lengths including a CS blip
        send_bad(23);
        send_bad(25);
        send_bad(0);
        wait_idle("badlen");

        // stalled output: DEPTH+1 held (one in WRITE), next one overflows
        rdy_mode = 0;
        cyc(2);
        base = acc_cnt;
        for (int k = 0; k < DEPTH + 2; k++) begin
            c = {8'($urandom_range(0, W-1)), 8'($urandom_range(0, H-1)), 8'($urandom)};
            send_cmd(c, k == DEPTH + 1);
        end
        cyc(4);
        check("stall_no_accept", 32'(acc_cnt - base), 32'(0));
        check("stall_overflow",  32'(ov_cnt), 32'(ov_exp));
        rdy_mode = 1;
        wait_idle("overflow_drain");

        // clear sweep
        send_cmd(24'hFF0011, 1'b0);
        wait_idle("clear");

        // out of range then valid
        send_cmd({8'(W), 8'h00, 8'h01}, 1'b0);
        send_cmd({8'h01, 8'(H), 8'h02}, 1'b0);
        send_cmd(24'h020155, 1'b0);
        wait_idle("range");

        // randomized mix with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                send_cmd({8'($urandom_range(0, W-1)), 8'($urandom_range(0, H-1)), 8'($urandom)}, 1'b0);
            end else if (r < 65) begin
                send_cmd({8'hFF, 8'($urandom), 8'($urandom)}, 1'b0);
            end else if (r < 80) begin
                if ($urandom_range(0, 1) == 0)
                    send_cmd({8'($urandom_range(W, 254)), 8'($urandom_range(0, H-1)), 8'($urandom)}, 1'b0);
                else
                    send_cmd({8'($urandom_range(0, W-1)), 8'($urandom_range(H, 255)), 8'($urandom)}, 1'b0);
            end else begin
                nb = $urandom_range(0, 32);
                if (nb == 24) nb = 23;
                send_bad(nb);
            end
            cyc($urandom_range(0, 20));
        end
        wait_idle("random");

        // reset in the middle of a clear with random backpressure
        base = acc_cnt;
        send_cmd(24'hFF005A, 1'b0);
        reached = 1'b0;
        for (int n = 0; n < 500 && !reached; n++) begin
            @(negedge clk);
            if (acc_cnt >= base + 3) reached = 1'b1;
        end
        check("midclear_reached", 32'(reached), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_valid", 32'(wr_valid), 32'(0));
        check("midrst_busy",     32'(busy),     32'(0));
        check("midrst_last_cmd", 32'(last_cmd), 32'(0));
        exp_q.delete();
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        send_cmd(24'h0100C3, 1'b0);
        wait_idle("after_reset");
        check("after_reset_last_cmd", 32'(last_cmd), 32'(24'h0100C3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
